// File: rtl/pad_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : pad_serial_tx
//  Description : Debounces three active-low pad buttons and sends their state
//                to the game board as an 8-bit serial frame. The frame is
//                start(0), btn0, btn1, btn2, seq0, seq1, even parity, stop(1),
//                LSB first. Every bit lasts BIT_DIV clocks. A frame is sent
//                whenever the debounced state differs from the last value
//                sent, and also after HEARTBEAT_CYCLES idle clocks.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  single clock, rising edge
//    rst_n        in   1  asynchronous active-low reset
//    i_btn_n      in   3  raw active-low buttons (bit0 attack, bit1 right,
//                         bit2 left), asynchronous to clk
//    o_tx         out  1  serial line, idle high
//    o_busy       out  1  high from the first START cycle to the last STOP
//                         cycle of a frame
//    o_btn_state  out  3  debounced active-high button state
//    o_seq        out  2  sequence number of the most recently started frame
// ============================================================================
module pad_serial_tx #(
    parameter int BIT_DIV          = 434,
    parameter int DEBOUNCE_CYCLES  = 250000,
    parameter int HEARTBEAT_CYCLES = 833333
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_btn_n,
    output logic       o_tx,
    output logic       o_busy,
    output logic [2:0] o_btn_state,
    output logic [1:0] o_seq
);

    // ------------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------------
    localparam int c_DIV_W = (BIT_DIV > 1)          ? $clog2(BIT_DIV)          : 1;
    localparam int c_DEB_W = (DEBOUNCE_CYCLES > 1)  ? $clog2(DEBOUNCE_CYCLES)  : 1;
    localparam int c_HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(BIT_DIV - 1);
    localparam logic [c_DEB_W-1:0] c_DEB_LAST = c_DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_HB_W-1:0]  c_HB_LAST  = c_HB_W'(HEARTBEAT_CYCLES - 1);

    // Index of the last payload bit sent in DATA (btn0..btn2, seq0, seq1)
    localparam logic [2:0] c_LAST_DATA_BIT = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]         r_sync1;
    logic [2:0]         r_sync2;
    logic [2:0]         w_btn_pressed;
    logic [2:0]         w_btn_state;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start_frame;
    logic               w_bit_end;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [2:0]         r_bit_idx;
    logic [6:0]         r_shift;
    logic               r_tx;
    logic               r_busy;
    logic [1:0]         r_seq;
    logic [1:0]         w_seq_next;
    logic [2:0]         r_last_sent;
    logic [c_HB_W-1:0]  r_hb_cnt;
    logic               w_hb_expired;
    logic               w_send_req;
    logic [4:0]         w_payload;
    logic               w_parity;

    // ------------------------------------------------------------------------
    // Two-flop synchronizer. Reset value 1 means "released" so no phantom
    // press is seen after reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b111;
            r_sync2 <= 3'b111;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_btn_pressed = ~r_sync2;

    // ------------------------------------------------------------------------
    // Per-button debounce. The counter runs only while the synced input
    // disagrees with the accepted state; any agreement restarts it, so a
    // glitch shorter than DEBOUNCE_CYCLES never reaches the accepted state.
    // ------------------------------------------------------------------------
    for (genvar b = 0; b < 3; b++) begin : g_debounce
        logic [c_DEB_W-1:0] r_deb_cnt;
        logic               r_state_bit;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_deb_cnt   <= '0;
                r_state_bit <= 1'b0;
            end else if (w_btn_pressed[b] == r_state_bit) begin
                r_deb_cnt   <= '0;
            end else if (r_deb_cnt == c_DEB_LAST) begin
                r_deb_cnt   <= '0;
                r_state_bit <= w_btn_pressed[b];
            end else begin
                r_deb_cnt   <= r_deb_cnt + c_DEB_W'(1);
            end
        end

        assign w_btn_state[b] = r_state_bit;
    end

    // ------------------------------------------------------------------------
    // Send request and frame content
    // ------------------------------------------------------------------------
    assign w_hb_expired = (r_hb_cnt == c_HB_LAST);
    assign w_send_req   = (w_btn_state != r_last_sent) || w_hb_expired;
    assign w_seq_next   = r_seq + 2'd1;
    assign w_payload    = {w_seq_next, w_btn_state};
    assign w_parity     = ^w_payload;
    assign w_bit_end    = (r_div_cnt == c_DIV_LAST);

    // ------------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next  = r_state;
        w_start_frame = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_send_req) begin
                    w_state_next  = S_START;
                    w_start_frame = 1'b1;
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == c_LAST_DATA_BIT)) begin
                    w_state_next = S_PARITY;
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bit timing: r_div_cnt counts clocks inside the current bit, r_bit_idx
    // counts payload bits while in DATA.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_bit_idx <= '0;
        end else begin
            if ((r_state == S_IDLE) || w_bit_end) begin
                r_div_cnt <= '0;
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end

            if (r_state != S_DATA) begin
                r_bit_idx <= '0;
            end else if (w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Serializer. The start bit is driven directly on frame start; the
    // remaining seven bits (payload, parity, stop) sit in r_shift and are
    // shifted out at each bit boundary. Ones are shifted in, so the line
    // returns high once STOP completes.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= 7'h7F;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else if (w_start_frame) begin
            r_shift <= {1'b1, w_parity, w_payload};
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
        end else if ((r_state != S_IDLE) && w_bit_end) begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b1, r_shift[6:1]};
            if (r_state == S_STOP) begin
                r_busy <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Frame bookkeeping: sequence number, last value sent and heartbeat.
    // The heartbeat counter only advances in IDLE and holds at its terminal
    // value, so an expiry raised together with a button change still
    // produces a single frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seq       <= 2'b11;
            r_last_sent <= 3'b000;
            r_hb_cnt    <= '0;
        end else if (w_start_frame) begin
            r_seq       <= w_seq_next;
            r_last_sent <= w_btn_state;
            r_hb_cnt    <= '0;
        end else if ((r_state == S_IDLE) && !w_hb_expired) begin
            r_hb_cnt    <= r_hb_cnt + c_HB_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_tx        = r_tx;
    assign o_busy      = r_busy;
    assign o_btn_state = w_btn_state;
    assign o_seq       = r_seq;

endmodule
`default_nettype wire
